ram_single_frame_ctrl: RTL and testbench
========================================

# ram_single_frame_ctrl

Frame buffer controller that owns the port of one single-port 18 Kb block RAM wrapper. It accepts a stream of FRAME_LEN signed samples and writes them to consecutive addresses from 0. It then reads the frame back as a valid/ready stream with backpressure. It sits between a sample producer (e.g. ADC/FFT input stage) and a consumer, and hides the RAM's one-cycle read latency behind a 2-entry output buffer.

## Interface
- ADDRESS_WIDTH, 7, RAM address width (1..10).
- DATA_WIDTH, 16, sample width; equals RAM WRITE_WIDTH/READ_WIDTH.
- FRAME_LEN, 2**ADDRESS_WIDTH, words per frame (1..2**ADDRESS_WIDTH).
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts input sample.
- in_data  in  DATA_WIDTH  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts output sample.
- out_data  out  DATA_WIDTH  signed output sample.
- out_last  out  1  qualifies the final word of a frame (valid only with out_valid).
- busy  out  1  high while in DRAIN.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  RAM address.
- ram_di  out  DATA_WIDTH  RAM write data (equals in_data).
- ram_do  in  DATA_WIDTH  RAM read data, valid one cycle after a read enable (DO_REG=0).

## Operation
- States: FILL, DRAIN. Reset puts the block in FILL.
- Reset values: in_ready=0 during reset, then 1 in FILL. out_valid=0, out_last=0, out_data=0, busy=0, ram_en=0, ram_we=0, ram_addr=0. Write pointer, read pointer and buffer count are 0. RAM contents are not cleared.
- FILL
  - in_ready=1.
  - An accept (in_valid && in_ready) drives ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_di=in_data combinationally in the same cycle.
  - wr_ptr increments on each accept.
  - The accept with wr_ptr==FRAME_LEN-1 moves the block to DRAIN and clears wr_ptr.
  - ram_en=0 when no accept occurs.
- DRAIN
  - in_ready=0, busy=1.
  - A read issue drives ram_en=1, ram_we=0, ram_addr=rd_ptr, then increments rd_ptr.
  - A read is issued iff rd_ptr<FRAME_LEN and (count + inflight − pop) < 2. Here inflight = a read was issued last cycle; pop = out_valid && out_ready this cycle.
  - The cycle after an issue, ram_do is written into the 2-entry FIFO.
  - The FIFO head drives out_data/out_valid (registered). out_last=1 when the head is word FRAME_LEN−1.
  - Popping the last word returns the block to FILL on the next cycle, with rd_ptr=0 and the FIFO empty.
- The FIFO never overflows. A word arriving from ram_do is never dropped, under any out_ready pattern.
- Simultaneous push and pop in one cycle leaves count unchanged; FIFO order is preserved.
- FRAME_LEN=1: a single write, a single read, then out_last is asserted on the only word.

## Timing
- Write: zero-cycle acceptance; RAM write occurs on the accept edge. Sustained 1 word/cycle.
- FILL→DRAIN: if the final write is accepted in cycle k:
  - busy=1 and the first read is issued in k+1;
  - ram_do is valid in k+2;
  - out_valid=1 in k+3.
- Read throughput: 1 word/cycle while out_ready=1. Frame drain takes FRAME_LEN+2 cycles from the first read issue to the last pop.
- After out_ready deasserts, at most one more read is issued; the FIFO then holds 2 words and issue stops. On out_ready reassertion, output resumes with no gap or duplicate.
- DRAIN→FILL: if the last pop is in cycle m, in_ready=1 in m+1.
- Synchronous reset mid-frame (either state) aborts the frame. Outputs take their reset values on the next edge, and the partial frame is discarded.

## Test plan
- ADDRESS_WIDTH=7, FRAME_LEN=128: write ramp 0..127 at 1/cycle, out_ready=1 → out_data 0..127 in order, out_valid first 3 cycles after the last accept, 128 consecutive valid cycles, out_last only on 127.
- Same frame with out_ready toggling randomly (50%) → identical in-order sequence, no loss/duplication, FIFO count never exceeds 2, ram_en with ram_we=0 never issued when count+inflight−pop≥2.
- in_valid gapped (1 of 3 cycles) with signed values −64..63 → RAM written only on accepts at addresses 0..127, sign preserved on readback.
- Two back-to-back frames (ramp, then ramp+1000) → in_ready low throughout DRAIN; second frame reads 1000..1127; in_ready high the cycle after the first frame's out_last pop.
- rst_n low for 1 cycle after 60 writes, then a full frame of 5s → all outputs at reset values after the reset edge; readback is 128×5 and the stale partial frame is never output.
- FRAME_LEN=1: write 0x1234 → one read, out_data=0x1234 with out_last=1, back in FILL the cycle after the pop.

Source files
------------

// File: rtl/ram_single_frame_ctrl.sv
// Single-frame buffer controller: fills one single-port RAM with a frame of samples,
// then drains it as a valid/ready stream through a 2-entry skid FIFO.
module ram_single_frame_ctrl #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAME_LEN     = 2**ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_di,
  input  logic [DATA_WIDTH-1:0]    ram_do
);

  localparam logic [ADDRESS_WIDTH-1:0] WR_LAST = ADDRESS_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDRESS_WIDTH:0]   RD_END  = (ADDRESS_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDRESS_WIDTH:0]   RD_LAST = (ADDRESS_WIDTH+1)'(FRAME_LEN - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH:0]   rd_ptr;
  logic [1:0]               count;
  logic                     inflight;
  logic                     inflight_last;
  logic [DATA_WIDTH-1:0]    head;
  logic                     head_last;
  logic [DATA_WIDTH-1:0]    tail;
  logic                     tail_last;

  logic accept;
  logic issue;
  logic pop;
  logic push;

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign out_last  = out_valid && head_last;
  assign busy      = (state == DRAIN);
  assign ram_di    = in_data;

  // A read may only issue if the word it returns is guaranteed a FIFO slot.
  always_comb begin
    accept   = (state == FILL) && in_valid && in_ready;
    pop      = out_valid && out_ready;
    push     = inflight;
    issue    = (state == DRAIN) && (rd_ptr < RD_END) &&
               (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    if (accept) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_ptr;
    end else if (issue) begin
      ram_en   = 1'b1;
      ram_addr = rd_ptr[ADDRESS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      in_ready      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      head          <= '0;
      head_last     <= 1'b0;
      tail          <= '0;
      tail_last     <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rd_ptr == RD_LAST);
      if (issue) rd_ptr <= rd_ptr + (ADDRESS_WIDTH+1)'(1);

      if (push && pop) begin
        if (count == 2'd2) begin
          head      <= tail;
          head_last <= tail_last;
          tail      <= ram_do;
          tail_last <= inflight_last;
        end else begin
          head      <= ram_do;
          head_last <= inflight_last;
        end
      end else if (pop) begin
        head      <= tail;
        head_last <= tail_last;
        count     <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          head      <= ram_do;
          head_last <= inflight_last;
        end else begin
          tail      <= ram_do;
          tail_last <= inflight_last;
        end
        count <= count + 2'd1;
      end

      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (wr_ptr == WR_LAST) begin
              wr_ptr   <= '0;
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state         <= FILL;
            in_ready      <= 1'b1;
            rd_ptr        <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_single_frame_ctrl.sv
// Self-checking bench for ram_single_frame_ctrl: table of frame scenarios with a
// data scoreboard, plus hand-written reset and FRAME_LEN=1 sequences.
module tb_ram_single_frame_ctrl;

  localparam int FL = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic        ram_en, ram_we;
  logic [15:0] in_data, out_data, ram_di, ram_do;
  logic [6:0]  ram_addr;
  logic [15:0] mem [0:127];

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic        ram_en1, ram_we1;
  logic [15:0] in_data1, out_data1, ram_di1, ram_do1;
  logic [0:0]  ram_addr1;
  logic [15:0] mem1 [0:1];

  int tick = 0;
  int total = 0;
  int passed = 0;
  int outstanding = 0;
  int max_out = 0;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } sb_item_t;
  sb_item_t sb[$];

  typedef struct {
    int gap;
    int rdy;
    int base;
    int step;
    int pre_writes;
    int exp_lat;
  } vec_t;
  vec_t vecs[6];

  ram_single_frame_ctrl #(.ADDRESS_WIDTH(7), .DATA_WIDTH(16), .FRAME_LEN(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  ram_single_frame_ctrl #(.ADDRESS_WIDTH(1), .DATA_WIDTH(16), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
    .busy(busy1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_di(ram_di1), .ram_do(ram_do1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
    if (ram_en1) begin
      if (ram_we1) mem1[ram_addr1] <= ram_di1;
      ram_do1 <= mem1[ram_addr1];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic sample_out();
    sb_item_t e;
    if (ram_en && !ram_we) outstanding++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
  endtask

  task automatic fill(input int n, input int gap, input int base, input int step,
                      input bit push, output int last_tick);
    int i = 0, c = 0, guard = 0, stray = 0;
    logic [15:0] v;
    last_tick = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      v = 16'(base + i * step);
      in_valid  = (c % gap == 0);
      in_data   = in_valid ? v : 16'hBEEF;
      out_ready = 1'b1;
      #1;
      sample_out();
      if (in_valid && in_ready) begin
        chk("wr_en_we", 32'({ram_en, ram_we}), 32'd3);
        chk("wr_addr", 32'(ram_addr), 32'(i));
        chk("wr_data", 32'(ram_di), 32'(v));
        if (push) sb.push_back('{d: v, last: (i == n - 1)});
        last_tick = tick;
        i++;
      end else if (ram_en) stray++;
      c++;
      guard++;
    end
    chk("fill_done", 32'(i), 32'(n));
    chk("stray_ram_en", 32'(stray), 32'd0);
  endtask

  task automatic drain(input vec_t v, input int last_acc);
    int guard = 0, first_tick = -1, vcyc = 0, bad_rdy = 0, bad_we = 0;
    bit done = 1'b0;
    while (!done && guard < 4000) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 16'h7777;
      out_ready = (v.rdy == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (tick == last_acc + 1) begin
        chk("busy_k1", 32'(busy), 32'd1);
        chk("in_ready_k1", 32'(in_ready), 32'd0);
        chk("first_read_k1", 32'({ram_en, ram_we, ram_addr}), 32'({2'b10, 7'd0}));
      end
      if (out_valid && first_tick < 0) first_tick = tick;
      if (out_valid) vcyc++;
      if (in_ready) bad_rdy++;
      if (ram_we) bad_we++;
      if (out_valid && out_ready && out_last) done = 1'b1;
      sample_out();
      guard++;
    end
    chk("drain_done", 32'(done), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("busy_after_pop", 32'(busy), 32'd0);
    chk("out_valid_after_pop", 32'(out_valid), 32'd0);
    chk("first_valid_latency", 32'(first_tick - last_acc), 32'(v.exp_lat));
    if (v.rdy == 0) chk("valid_cycles", 32'(vcyc), 32'(FL));
    chk("in_ready_low_in_drain", 32'(bad_rdy), 32'd0);
    chk("no_write_in_drain", 32'(bad_we), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_en_we", 32'({ram_en, ram_we}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
  endtask

  initial begin
    int lt;
    //           gap rdy  base  step pre  lat
    vecs[0] = '{1,  0,   0,    1,   0,   3};
    vecs[1] = '{1,  1,   0,    1,   0,   3};
    vecs[2] = '{3,  0,   -64,  1,   0,   3};
    vecs[3] = '{1,  0,   0,    1,   0,   3};
    vecs[4] = '{1,  0,   1000, 1,   0,   3};
    vecs[5] = '{1,  0,   5,    0,   60,  3};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    chk("rst1_in_ready", 32'(in_ready1), 32'd0);
    chk("rst1_out_valid", 32'(out_valid1), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      if (vecs[t].pre_writes > 0) begin
        fill(vecs[t].pre_writes, 1, 100, 1, 1'b0, lt);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        sb.delete();
      end
      outstanding = 0;
      max_out = 0;
      fill(FL, vecs[t].gap, vecs[t].base, vecs[t].step, 1'b1, lt);
      drain(vecs[t], lt);
    end

    // FRAME_LEN=1: accept in k, read in k+1, data valid k+3, back in FILL k+4
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 16'h1234; out_ready1 = 1'b1;
    #1;
    chk("f1_in_ready", 32'(in_ready1), 32'd1);
    chk("f1_write", 32'({ram_en1, ram_we1, ram_addr1}), 32'b110);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    chk("f1_busy", 32'(busy1), 32'd1);
    chk("f1_read", 32'({ram_en1, ram_we1, ram_addr1}), 32'b100);
    @(negedge clk);
    #1;
    chk("f1_valid_k2", 32'(out_valid1), 32'd0);
    @(negedge clk);
    #1;
    chk("f1_valid_k3", 32'(out_valid1), 32'd1);
    chk("f1_data", 32'(out_data1), 32'h1234);
    chk("f1_last", 32'(out_last1), 32'd1);
    @(negedge clk);
    #1;
    chk("f1_in_ready_after", 32'(in_ready1), 32'd1);
    chk("f1_busy_after", 32'(busy1), 32'd0);
    chk("f1_valid_after", 32'(out_valid1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
